keyboard_ctrl: RTL and testbench

Sequencer between the PS/2 receiver and the registered-address scancode ROM. Consumes raw scancode bytes, strips break (F0) and extended (E0) prefixes, tracks Shift, Caps Lock and layout-select state, and forms the 10-bit ROM address {lang_sel, shifted, scan_code}. It waits out the ROM's one-cycle address register and emits a one-cycle character strobe to the text/display logic. ROM codes 8'h00 and 8'hFF are filtered out.

---
 rtl/keyboard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_keyboard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_ctrl.sv
// keyboard_ctrl: turns raw PS/2 scancode bytes into ROM lookups and one-cycle character strobes.
// Ports: clk, reset_n (async active-low), scan_code/scan_valid in, rom_addr out / rom_data in,
//        char_out/char_valid, shift_active, caps_lock, lang_sel, overrun (sticky) out.
module keyboard_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [9:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       shift_active,
    output logic       caps_lock,
    output logic       lang_sel,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK,
        LK1,
        LK2
    } state_t;

    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_LSH  = 8'h12;
    localparam logic [7:0] SC_RSH  = 8'h59;
    localparam logic [7:0] SC_CAPS = 8'h58;
    localparam logic [7:0] SC_LANG = 8'h0E;

    state_t     state_q, state_d;
    logic [9:0] rom_addr_q, rom_addr_d;
    logic [7:0] char_out_q, char_out_d;
    logic       char_valid_q, char_valid_d;
    logic       lsh_q, lsh_d;
    logic       rsh_q, rsh_d;
    logic       caps_q, caps_d;
    logic       caps_held_q, caps_held_d;
    logic       lang_q, lang_d;
    logic       lang_held_q, lang_held_d;
    logic       overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        char_out_d   = char_out_q;
        char_valid_d = 1'b0;
        lsh_d        = lsh_q;
        rsh_d        = rsh_q;
        caps_d       = caps_q;
        caps_held_d  = caps_held_q;
        lang_d       = lang_q;
        lang_held_d  = lang_held_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (scan_valid) begin
                    if (scan_code == SC_BRK) begin
                        state_d = BRK;
                    end else if (scan_code == SC_EXT) begin
                        state_d = EXT;
                    end else if (scan_code == SC_LSH) begin
                        lsh_d = 1'b1;
                    end else if (scan_code == SC_RSH) begin
                        rsh_d = 1'b1;
                    end else if (scan_code == SC_CAPS) begin
                        // Typematic repeats arrive while held; toggle only on first make.
                        if (!caps_held_q) begin
                            caps_d      = ~caps_q;
                            caps_held_d = 1'b1;
                        end
                    end else if (scan_code == SC_LANG) begin
                        if (!lang_held_q) begin
                            lang_d      = ~lang_q;
                            lang_held_d = 1'b1;
                        end
                    end else begin
                        // Modifiers are frozen into the address here.
                        rom_addr_d = {lang_q, (lsh_q | rsh_q) ^ caps_q, scan_code};
                        state_d    = LK1;
                    end
                end
            end
            BRK: begin
                if (scan_valid) begin
                    if (scan_code == SC_LSH) begin
                        lsh_d = 1'b0;
                    end else if (scan_code == SC_RSH) begin
                        rsh_d = 1'b0;
                    end else if (scan_code == SC_CAPS) begin
                        caps_held_d = 1'b0;
                    end else if (scan_code == SC_LANG) begin
                        lang_held_d = 1'b0;
                    end
                    state_d = IDLE;
                end
            end
            EXT: begin
                if (scan_valid) begin
                    state_d = (scan_code == SC_BRK) ? EXT_BRK : IDLE;
                end
            end
            EXT_BRK: begin
                if (scan_valid) begin
                    state_d = IDLE;
                end
            end
            LK1: begin
                // ROM registers rom_addr on this edge.
                if (scan_valid) begin
                    overrun_d = 1'b1;
                end
                state_d = LK2;
            end
            LK2: begin
                if (scan_valid) begin
                    overrun_d = 1'b1;
                end
                if (rom_data != 8'h00 && rom_data != 8'hFF) begin
                    char_out_d   = rom_data;
                    char_valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rom_addr_q   <= '0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
            lsh_q        <= 1'b0;
            rsh_q        <= 1'b0;
            caps_q       <= 1'b0;
            caps_held_q  <= 1'b0;
            lang_q       <= 1'b0;
            lang_held_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            lsh_q        <= lsh_d;
            rsh_q        <= rsh_d;
            caps_q       <= caps_d;
            caps_held_q  <= caps_held_d;
            lang_q       <= lang_d;
            lang_held_q  <= lang_held_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign char_out     = char_out_q;
    assign char_valid   = char_valid_q;
    assign shift_active = lsh_q | rsh_q;
    assign caps_lock    = caps_q;
    assign lang_sel     = lang_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_keyboard_ctrl.sv
// tb_keyboard_ctrl: scoreboard bench for keyboard_ctrl with a registered ROM model.
// Expected characters are queued when keys are sent and popped when char_valid fires.
module tb_keyboard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic [9:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] char_out;
    logic       char_valid;
    logic       shift_active;
    logic       caps_lock;
    logic       lang_sel;
    logic       overrun;

    int errs = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic prev_cv = 1'b0;

    keyboard_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .char_out     (char_out),
        .char_valid   (char_valid),
        .shift_active (shift_active),
        .caps_lock    (caps_lock),
        .lang_sel     (lang_sel),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [9:0] a);
        case (a)
            10'h01C: rom_fn = 8'h61;
            10'h11C: rom_fn = 8'h41;
            10'h21C: rom_fn = 8'h1F;
            10'h31E: rom_fn = 8'hFF;
            10'h01E: rom_fn = 8'h32;
            10'h032: rom_fn = 8'h62;
            default: rom_fn = 8'h00;
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (char_valid) begin
            if (prev_cv) chk("cv_twice", 1, 0);
            if (exp_q.size() == 0) begin
                chk("spurious_char", {24'h0, char_out}, 32'h1FF);
            end else begin
                chk("char", {24'h0, char_out}, {24'h0, exp_q.pop_front()});
            end
        end
        prev_cv <= char_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one byte; returns at the negedge right after the sampling edge.
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        scan_code  = c;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic key(input logic [7:0] c, input bit has_char, input logic [7:0] ch);
        if (has_char) exp_q.push_back(ch);
        send(c);
        idle(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle(2);
        chk("rst_addr", {22'h0, rom_addr}, 0);
        chk("rst_char", {24'h0, char_out}, 0);
        chk("rst_cv", {31'h0, char_valid}, 0);
        chk("rst_mods", {29'h0, shift_active, caps_lock, lang_sel}, 0);
        chk("rst_ovr", {31'h0, overrun}, 0);
        reset_n = 1'b1;
        idle(2);

        // Basic lookup with exact latency.
        exp_q.push_back(8'h61);
        send(8'h1C);
        chk("t1_addr", {22'h0, rom_addr}, 32'h01C);
        chk("t1_cv_n0", {31'h0, char_valid}, 0);
        idle(1);
        chk("t1_cv_n1", {31'h0, char_valid}, 0);
        idle(1);
        chk("t1_cv_n2", {31'h0, char_valid}, 1);
        chk("t1_char", {24'h0, char_out}, 32'h61);
        idle(1);
        chk("t1_cv_low", {31'h0, char_valid}, 0);
        idle(2);

        // Shift.
        key(8'h12, 0, 8'h00);
        chk("t2_shift", {31'h0, shift_active}, 1);
        exp_q.push_back(8'h41);
        send(8'h1C);
        chk("t2_addr", {22'h0, rom_addr}, 32'h11C);
        idle(3);
        key(8'hF0, 0, 8'h00);
        key(8'h12, 0, 8'h00);
        chk("t2_shift_off", {31'h0, shift_active}, 0);
        key(8'h1C, 1, 8'h61);

        // Caps with typematic repeat.
        key(8'h58, 0, 8'h00);
        key(8'h58, 0, 8'h00);
        key(8'h58, 0, 8'h00);
        key(8'hF0, 0, 8'h00);
        key(8'h58, 0, 8'h00);
        chk("t3_caps", {31'h0, caps_lock}, 1);
        key(8'h1C, 1, 8'h41);
        key(8'h12, 0, 8'h00);
        key(8'h1C, 1, 8'h61);
        key(8'hF0, 0, 8'h00);
        key(8'h12, 0, 8'h00);
        key(8'h58, 0, 8'h00);
        key(8'hF0, 0, 8'h00);
        key(8'h58, 0, 8'h00);
        chk("t3_caps_off", {31'h0, caps_lock}, 0);

        // Break / extended sequences produce nothing.
        key(8'hF0, 0, 8'h00);
        key(8'h1C, 0, 8'h00);
        key(8'hE0, 0, 8'h00);
        key(8'h75, 0, 8'h00);
        key(8'hE0, 0, 8'h00);
        key(8'hF0, 0, 8'h00);
        key(8'h75, 0, 8'h00);
        key(8'h1C, 1, 8'h61);
        key(8'h1E, 1, 8'h32);

        // Layout select and ROM filter.
        key(8'h0E, 0, 8'h00);
        key(8'hF0, 0, 8'h00);
        key(8'h0E, 0, 8'h00);
        chk("t5_lang", {31'h0, lang_sel}, 1);
        exp_q.push_back(8'h1F);
        send(8'h1C);
        chk("t5_addr", {22'h0, rom_addr}, 32'h21C);
        idle(3);
        key(8'h12, 0, 8'h00);
        send(8'h1E);
        chk("t5_addr_ff", {22'h0, rom_addr}, 32'h31E);
        idle(3);
        key(8'hF0, 0, 8'h00);
        key(8'h12, 0, 8'h00);
        key(8'h0E, 0, 8'h00);
        key(8'hF0, 0, 8'h00);
        key(8'h0E, 0, 8'h00);
        chk("t5_lang_off", {31'h0, lang_sel}, 0);

        // Overrun: second byte lands in LK1 and is dropped.
        chk("t6_ovr0", {31'h0, overrun}, 0);
        exp_q.push_back(8'h61);
        send(8'h1C);
        scan_code  = 8'h32;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        idle(4);
        chk("t6_ovr", {31'h0, overrun}, 1);
        chk("t6_addr", {22'h0, rom_addr}, 32'h01C);

        // Reset during LK1 aborts lookup.
        key(8'h12, 0, 8'h00);
        send(8'h1C);
        reset_n = 1'b0;
        #1;
        chk("t7_cv", {31'h0, char_valid}, 0);
        chk("t7_ovr", {31'h0, overrun}, 0);
        chk("t7_addr", {22'h0, rom_addr}, 0);
        chk("t7_mods", {29'h0, shift_active, caps_lock, lang_sel}, 0);
        idle(2);
        reset_n = 1'b1;
        idle(5);
        chk("t7_char", {24'h0, char_out}, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
